prog_loader: RTL and testbench

- Byte-stream program loader: the write side of the CPU's instruction memory, which the CPU fetch path only reads.
- Receives a framed program image over a valid/ready byte interface.
- Assembles 16-bit instruction words and writes them into instruction memory from address 0.
- Holds the CPU in reset (cpu_hold) until a complete, valid image has been written; then releases it.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/prog_loader.sv | 146 ++++++++++++++
 tb/tb_prog_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cpu_pkg                                                   |
// | Purpose  : Constants shared by the program loader and CPU fetch path |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam int         INSTR_W   = 16;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int         STATE_W   = 3;
    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_LEN  = 3'd1;
    localparam logic [STATE_W-1:0] ST_HI   = 3'd2;
    localparam logic [STATE_W-1:0] ST_LO   = 3'd3;
    localparam logic [STATE_W-1:0] ST_CSUM = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd5;
    localparam logic [STATE_W-1:0] ST_ERR  = 3'd6;

endpackage
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : prog_loader                                               |
// | Purpose  : Framed byte-stream loader writing 16-bit big-endian words |
// |            into instruction memory; holds the CPU until loaded.      |
// |            Define PROG_LOADER_CSUM_EN to require a trailing XOR      |
// |            checksum byte.                                            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module prog_loader #(
    parameter int         ADDR_W    = 8,
    parameter int         INSTR_W   = cpu_pkg::INSTR_W,
    parameter logic [7:0] SYNC_BYTE = cpu_pkg::SYNC_BYTE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);
    import cpu_pkg::*;

    logic [STATE_W-1:0] state_q, state_d;
    logic [7:0]         n_q, n_d;
    logic [ADDR_W-1:0]  word_idx_q, word_idx_d;
    logic [7:0]         hi_q, hi_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] mem_wdata_q, mem_wdata_d;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif
    logic               accept;
    logic               last_word;

    assign accept    = in_valid && in_ready;
    assign last_word = (word_idx_q == ADDR_W'(n_q - 8'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            word_idx_q  <= '0;
            hi_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef PROG_LOADER_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_idx_q  <= word_idx_d;
            hi_q        <= hi_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef PROG_LOADER_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_idx_d  = word_idx_q;
        hi_d        = hi_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CSUM_EN
        csum_d      = csum_q;
`endif
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_data == SYNC_BYTE) state_d = ST_LEN;
                end
                ST_LEN: begin
                    n_d        = in_data;
                    word_idx_d = '0;
`ifdef PROG_LOADER_CSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = (in_data == 8'd0) ? ST_ERR : ST_HI;
                end
                ST_HI: begin
                    hi_d    = in_data;
`ifdef PROG_LOADER_CSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                    state_d = ST_LO;
                end
                ST_LO: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_idx_q;
                    mem_wdata_d = INSTR_W'({hi_q, in_data});
                    word_idx_d  = word_idx_q + 1'b1;
`ifdef PROG_LOADER_CSUM_EN
                    csum_d      = csum_q ^ in_data;
                    state_d     = last_word ? ST_CSUM : ST_HI;
`else
                    state_d     = last_word ? ST_DONE : ST_HI;
`endif
                end
`ifdef PROG_LOADER_CSUM_EN
                ST_CSUM: begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // Status outputs decode straight from state so they move on the accepting edge.
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;
        case (state_q)
            ST_IDLE, ST_LEN, ST_HI, ST_LO, ST_CSUM: in_ready = 1'b1;
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ST_ERR:  err = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_prog_loader                                            |
// | Purpose  : Directed self-checking bench for prog_loader              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // write log captured by the monitor
    logic [7:0]  wa [0:31];
    logic [15:0] wd [0:31];
    logic        wdone [0:31];
    int          nwr = 0;
    int          adj = 0;
    logic        prev_we = 1'b0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (nwr < 32) begin
                wa[nwr]    = mem_addr;
                wd[nwr]    = mem_wdata;
                wdone[nwr] = done;
            end
            nwr = nwr + 1;
            if (prev_we) adj = adj + 1;
        end
        prev_we = (mem_we === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        tries    = 0;
        while (in_ready !== 1'b1 && tries < 16) begin
            @(negedge clk);
            tries++;
        end
        if (in_ready !== 1'b1) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    int base;

    initial begin
        apply_reset();
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_hold",  32'(cpu_hold), 32'd1);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_we",    32'(mem_we), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);

        // two-word frame, back to back
        base = nwr;
        send_byte(8'hA5, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
`ifdef PROG_LOADER_CSUM_EN
        send_byte(8'h40, 0);
`endif
        settle();
        check("a_nwr",   32'(nwr - base), 32'd2);
        check("a_w0",    {8'h0, wa[base], wd[base]}, {8'h0, 8'h00, 16'h1234});
        check("a_w1",    {8'h0, wa[base+1], wd[base+1]}, {8'h0, 8'h01, 16'hABCD});
        check("a_done",  32'(done), 32'd1);
        check("a_hold",  32'(cpu_hold), 32'd0);
        check("a_err",   32'(err), 32'd0);
        check("a_ready", 32'(in_ready), 32'd0);

`ifdef PROG_LOADER_CSUM_EN
        // bad checksum
        apply_reset();
        base = nwr;
        send_byte(8'hA5, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        send_byte(8'h41, 0);
        settle();
        check("b_nwr",  32'(nwr - base), 32'd2);
        check("b_err",  32'(err), 32'd1);
        check("b_hold", 32'(cpu_hold), 32'd1);
        check("b_done", 32'(done), 32'd0);
`endif

        // leading junk and random gaps, single word
        apply_reset();
        base = nwr;
        adj  = 0;
        send_byte(8'h00, int'($urandom_range(0, 3)));
        send_byte(8'hFF, int'($urandom_range(0, 3)));
        send_byte(8'hA5, int'($urandom_range(0, 3)));
        send_byte(8'h01, int'($urandom_range(0, 3)));
        send_byte(8'h00, int'($urandom_range(0, 3)));
        send_byte(8'h07, int'($urandom_range(0, 3)));
`ifdef PROG_LOADER_CSUM_EN
        send_byte(8'h07, int'($urandom_range(0, 3)));
`endif
        settle();
        check("c_nwr",  32'(nwr - base), 32'd1);
        check("c_w0",   {8'h0, wa[base], wd[base]}, {8'h0, 8'h00, 16'h0007});
        check("c_width", 32'(adj), 32'd0);
        check("c_done", 32'(done), 32'd1);

        // zero-length frame
        apply_reset();
        base = nwr;
        send_byte(8'hA5, 0); send_byte(8'h00, 0);
        @(negedge clk);
        check("d_err",   32'(err), 32'd1);
        check("d_hold",  32'(cpu_hold), 32'd1);
        check("d_ready", 32'(in_ready), 32'd0);
        settle();
        check("d_nwr",   32'(nwr - base), 32'd0);

        // reset coinciding with the final payload byte of word 1
        apply_reset();
        base = nwr;
        send_byte(8'hA5, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hCD;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("e_we",    32'(mem_we), 32'd0);
        check("e_ready", 32'(in_ready), 32'd1);
        check("e_hold",  32'(cpu_hold), 32'd1);
        check("e_flags", {30'd0, done, err}, 32'd0);
        settle();
        check("e_nwr",   32'(nwr - base), 32'd1);
        check("e_w0",    32'(wa[base]), 32'd0);

        // good frame after the abort; done timing relative to the last write
        base = nwr;
        send_byte(8'hA5, 0); send_byte(8'h01, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0);
`ifdef PROG_LOADER_CSUM_EN
        send_byte(8'h73, 0);
`endif
        settle();
        check("f_nwr",  32'(nwr - base), 32'd1);
        check("f_w0",   {8'h0, wa[base], wd[base]}, {8'h0, 8'h00, 16'hDEAD});
        check("f_done", 32'(done), 32'd1);
        check("f_hold", 32'(cpu_hold), 32'd0);
`ifdef PROG_LOADER_CSUM_EN
        check("f_done_at_we", 32'(wdone[base]), 32'd0);
`else
        check("f_done_at_we", 32'(wdone[base]), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
